// File: rtl/div_iter_seq.sv
// Iterative restoring divider: one quotient bit per clock over a 2*WIDTH {rem, quo} register.
// Optional two's-complement operation is enabled by defining DIV_SIGNED_EN.
module div_iter_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [2*WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic               dbz_reg, dbz_next;

  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH-1:0]   quo_final;
  logic [WIDTH-1:0]   rem_final;

`ifdef DIV_SIGNED_EN
  logic neg_quo_reg, neg_quo_next;
  logic neg_rem_reg, neg_rem_next;

  // Magnitudes are taken as unsigned WIDTH-bit values, so the most-negative
  // operand keeps its bit pattern and still divides correctly.
  assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign quo_final    = neg_quo_reg ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
  assign rem_final    = neg_rem_reg ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign quo_final    = step[WIDTH-1:0];
  assign rem_final    = step[2*WIDTH-1:WIDTH];
`endif

  // Trial window is the upper half after a shift-left-by-one.
  assign trial = work_reg[2*WIDTH-2:WIDTH-1];
  assign diff  = trial - divisor_reg;
  assign step  = (trial >= divisor_reg) ? {diff, work_reg[WIDTH-2:0], 1'b1}
                                        : {work_reg[2*WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dbz_reg     <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      work_reg    <= work_next;
      divisor_reg <= divisor_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      dbz_reg     <= dbz_next;
`ifdef DIV_SIGNED_EN
      neg_quo_reg <= neg_quo_next;
      neg_rem_reg <= neg_rem_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    work_next    = work_reg;
    divisor_next = divisor_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    dbz_next     = dbz_reg;
    busy         = 1'b0;
    done         = 1'b0;
`ifdef DIV_SIGNED_EN
    neg_quo_next = neg_quo_reg;
    neg_rem_next = neg_rem_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next    = {{WIDTH{1'b0}}, dividend_mag};
          divisor_next = divisor_mag;
          count_next   = '0;
          dbz_next     = 1'b0;
`ifdef DIV_SIGNED_EN
          neg_quo_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_rem_next = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            // Zero divisor skips iteration; the raw dividend is reported as remainder.
            quo_next   = {WIDTH{1'b1}};
            rem_next   = dividend;
            dbz_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        busy       = 1'b1;
        work_next  = step;
        count_next = count_reg + 1'b1;
        if (count_reg == CW'(WIDTH - 1)) begin
          quo_next   = quo_final;
          rem_next   = rem_final;
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign quotient    = quo_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_iter_seq.sv
// Self-checking bench for div_iter_seq: directed cases plus random operands against an arithmetic model.
module tb_div_iter_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fails  = 0;

  div_iter_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int ma, mb, qi, ri;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      ma = int'($signed(a)); mb = int'($signed(b));
      qi = (ma < 0 ? -ma : ma) / (mb < 0 ? -mb : mb);
      ri = (ma < 0 ? -ma : ma) % (mb < 0 ? -mb : mb);
      if ((ma < 0) != (mb < 0)) qi = -qi;
      if (ma < 0) ri = -ri;
`else
      ma = int'(a); mb = int'(b);
      qi = ma / mb;
      ri = ma % mb;
`endif
      q = W'(qi); r = W'(ri); z = 1'b0;
    end
  endtask

  // Issue one operation, optionally pulse a stray start at cycle inj, and check the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    logic [W-1:0] eq, er;
    logic ez;
    int cyc, lat;
    bit seen;
    model(a, b, eq, er, ez);
    lat = (b == 0) ? 1 : W + 1;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    seen = 1'b0;
    cyc = 1;
    while (cyc <= 40) begin
      if (cyc == inj) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    check("busy_at_done", 32'(busy), 32'd1);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    $display("op %h / %h : q=%h r=%h dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, cyc);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run_op(16'd100, 16'd7, 0);
    run_op(16'hFFFF, 16'h0001, 0);
    run_op(16'h0003, 16'h0010, 0);
    run_op(16'd5, 16'd0, 0);
    run_op(16'd9, 16'd3, 0);

    // Stray start while busy must be ignored; results then hold while idle.
    run_op(16'd100, 16'd7, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_quotient", 32'(quotient), 32'd14);
      check("hold_remainder", 32'(remainder), 32'd2);
      check("hold_done", 32'(done), 32'd0);
    end

    // Reset mid-run clears outputs at once and suppresses done.
    @(negedge clk);
    dividend = 16'd100; divisor = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op(16'd20, 16'd6, 0);

`ifdef DIV_SIGNED_EN
    run_op(16'hFF9C, 16'd7, 0);
    run_op(16'd100, 16'hFFF9, 0);
    run_op(16'h8000, 16'hFFFF, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = W'($urandom_range(0, 3));
        1:       rb = W'($urandom_range(0, 255));
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, (i % 5 == 0) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
